// File: rtl/debug_state_dumper_pkg.sv
// Shared definitions for the debug state dumper: widths, frame section sizes
// and the dump FSM state encoding.
package debug_state_dumper_pkg;

  localparam int SIZE          = 32;
  localparam int NUM_REGISTERS = 32;
  localparam int MEM_SIZE      = 64;
  localparam int ADDR_WIDTH    = $clog2(MEM_SIZE);
  localparam int IF_ID_SIZE    = 64;
  localparam int ID_EX_SIZE    = 129;
  localparam int EX_MEM_SIZE   = 78;
  localparam int MEM_WB_SIZE   = 72;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam int WORD_BYTES   = SIZE / 8;
  localparam int WORD_SHIFT   = $clog2(WORD_BYTES);
  localparam int PC_BYTES     = WORD_BYTES;
  localparam int REG_BYTES    = NUM_REGISTERS * WORD_BYTES;
  localparam int IF_ID_BYTES  = (IF_ID_SIZE + 7) / 8;
  localparam int ID_EX_BYTES  = (ID_EX_SIZE + 7) / 8;
  localparam int EX_MEM_BYTES = (EX_MEM_SIZE + 7) / 8;
  localparam int MEM_WB_BYTES = (MEM_WB_SIZE + 7) / 8;
  localparam int LATCH_BYTES  = IF_ID_BYTES + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;
  localparam int LATCH_BITS   = LATCH_BYTES * 8;
  localparam int MEM_BYTES    = MEM_SIZE * WORD_BYTES;

  // The byte-in-section counter must reach the largest section's last index.
  localparam int MAX_BYTES = (MEM_BYTES > REG_BYTES)
                             ? ((MEM_BYTES > LATCH_BYTES) ? MEM_BYTES : LATCH_BYTES)
                             : ((REG_BYTES > LATCH_BYTES) ? REG_BYTES : LATCH_BYTES);
  localparam int CNT_W = $clog2(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_PC     = 3'd2,
    ST_REGS   = 3'd3,
    ST_LATCH  = 3'd4,
    ST_MEM    = 3'd5,
    ST_CHECK  = 3'd6
  } dump_state_e;

endpackage

// File: rtl/debug_state_dumper_byte_select.sv
// Combinational byte picker: returns byte idx of the PC, register or latch
// snapshot, or of the live memory word, for the given frame section.
module dump_byte_select
  import debug_state_dumper_pkg::*;
(
  input  logic [2:0]                    section,
  input  logic [CNT_W-1:0]              idx,
  input  logic [SIZE-1:0]               pc_snap,
  input  logic [NUM_REGISTERS*SIZE-1:0] regs_snap,
  input  logic [LATCH_BITS-1:0]         latch_snap,
  input  logic [SIZE-1:0]               mem_word,
  output logic [7:0]                    data
);

  localparam int WORD_SEL_W  = $clog2(SIZE);
  localparam int REG_SEL_W   = $clog2(NUM_REGISTERS * SIZE);
  localparam int LATCH_SEL_W = $clog2(LATCH_BITS);

  logic [CNT_W+2:0] bit_off;

  assign bit_off = {idx, 3'b000};

  // Truncating the bit offset to the word width gives the byte-in-word
  // position, which is what the MEM section needs.
  always_comb begin
    data = '0;
    case (section)
      ST_PC:    data = pc_snap[WORD_SEL_W'(bit_off) +: 8];
      ST_REGS:  data = regs_snap[REG_SEL_W'(bit_off) +: 8];
      ST_LATCH: data = latch_snap[LATCH_SEL_W'(bit_off) +: 8];
      ST_MEM:   data = mem_word[WORD_SEL_W'(bit_off) +: 8];
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/debug_state_dumper.sv
// Snapshots PC, registers and pipeline latches on request, then streams them
// plus live data memory as a checksummed frame into the UART TX FIFO.
module debug_state_dumper
  import debug_state_dumper_pkg::*;
(
  input  logic                          clk_to_use,
  input  logic                          i_rst,
  input  logic                          i_dump_req,
  input  logic [SIZE-1:0]               i_pc,
  input  logic [NUM_REGISTERS*SIZE-1:0] i_registers_debug,
  input  logic [IF_ID_SIZE-1:0]         i_IF_ID,
  input  logic [ID_EX_SIZE-1:0]         i_ID_EX,
  input  logic [EX_MEM_SIZE-1:0]        i_EX_MEM,
  input  logic [MEM_WB_SIZE-1:0]        i_MEM_WB,
  input  logic [SIZE-1:0]               i_debug_data,
  input  logic                          i_tx_full,
  output logic [ADDR_WIDTH-1:0]         o_debug_addr,
  output logic                          o_tx_start,
  output logic [7:0]                    o_tx_data,
  output logic                          o_busy,
  output logic                          o_done
);

  dump_state_e                   state, state_nxt;
  logic [CNT_W-1:0]              idx, idx_nxt, last_idx;
  logic [7:0]                    chk, chk_nxt, sel_byte;
  logic                          done_q, done_nxt;
  logic                          push, last_byte;
  logic [SIZE-1:0]               pc_snap;
  logic [NUM_REGISTERS*SIZE-1:0] regs_snap;
  logic [LATCH_BITS-1:0]         latch_snap;
  logic [ID_EX_BYTES*8-1:0]      id_ex_pad;
  logic [EX_MEM_BYTES*8-1:0]     ex_mem_pad;

  assign id_ex_pad  = (ID_EX_BYTES * 8)'(i_ID_EX);
  assign ex_mem_pad = (EX_MEM_BYTES * 8)'(i_EX_MEM);

  always_ff @(posedge clk_to_use or posedge i_rst) begin
    if (i_rst) begin
      pc_snap    <= '0;
      regs_snap  <= '0;
      latch_snap <= '0;
    end else if (state == ST_IDLE && i_dump_req) begin
      pc_snap    <= i_pc;
      regs_snap  <= i_registers_debug;
      latch_snap <= {i_MEM_WB, ex_mem_pad, id_ex_pad, i_IF_ID};
    end
  end

  always_ff @(posedge clk_to_use or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      chk    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      chk    <= chk_nxt;
      done_q <= done_nxt;
    end
  end

  dump_byte_select u_sel (
    .section    (state),
    .idx        (idx),
    .pc_snap    (pc_snap),
    .regs_snap  (regs_snap),
    .latch_snap (latch_snap),
    .mem_word   (i_debug_data),
    .data       (sel_byte)
  );

  always_comb begin
    last_idx = '0;
    case (state)
      ST_PC:    last_idx = CNT_W'(PC_BYTES - 1);
      ST_REGS:  last_idx = CNT_W'(REG_BYTES - 1);
      ST_LATCH: last_idx = CNT_W'(LATCH_BYTES - 1);
      ST_MEM:   last_idx = CNT_W'(MEM_BYTES - 1);
      default:  last_idx = '0;
    endcase
  end

  // FIFO push: o_tx_start is high exactly in a sending cycle with i_tx_full=0,
  // and o_tx_data is valid in that same cycle; while full, everything holds.
  assign push      = (state != ST_IDLE) && !i_tx_full;
  assign last_byte = (idx == last_idx);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    chk_nxt   = chk;
    done_nxt  = 1'b0;
    if (state == ST_IDLE) begin
      if (i_dump_req) begin
        state_nxt = ST_HEADER;
        idx_nxt   = '0;
        chk_nxt   = '0;
      end
    end else if (push) begin
      if (state != ST_HEADER && state != ST_CHECK) chk_nxt = chk ^ sel_byte;
      if (last_byte) begin
        idx_nxt = '0;
        case (state)
          ST_HEADER: state_nxt = ST_PC;
          ST_PC:     state_nxt = ST_REGS;
          ST_REGS:   state_nxt = ST_LATCH;
          ST_LATCH:  state_nxt = ST_MEM;
          ST_MEM:    state_nxt = ST_CHECK;
          default: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        endcase
      end else begin
        idx_nxt = idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_tx_data = '0;
    if (push) begin
      case (state)
        ST_HEADER: o_tx_data = HEADER_BYTE;
        ST_CHECK:  o_tx_data = chk;
        default:   o_tx_data = sel_byte;
      endcase
    end
  end

  assign o_tx_start   = push;
  assign o_busy       = (state != ST_IDLE);
  assign o_done       = done_q;
  assign o_debug_addr = (state == ST_MEM) ? ADDR_WIDTH'(idx >> WORD_SHIFT) : '0;

endmodule
